// File: rtl/uart_pkg.sv
// Register map, status/control bit positions and the frame-state encoding
// shared by the UART TX and RX state machines.
package uart_pkg;

  localparam logic [1:0] REG_USR = 2'd0;
  localparam logic [1:0] REG_UCR = 2'd1;
  localparam logic [1:0] REG_UTX = 2'd2;
  localparam logic [1:0] REG_URX = 2'd3;

  localparam int USR_RX_NOT_EMPTY = 0;
  localparam int USR_TX_NOT_FULL  = 1;
  localparam int USR_TX_EMPTY     = 2;
  localparam int USR_RX_FULL      = 3;
  localparam int USR_OVERRUN      = 4;
  localparam int USR_PARITY_ERR   = 5;
  localparam int USR_FRAME_ERR    = 6;
  localparam int USR_RX_LEVEL_LSB = 16;
  localparam int USR_TX_LEVEL_LSB = 24;

  localparam int UCR_PAR_EN  = 16;
  localparam int UCR_PAR_ODD = 17;
  localparam int UCR_STOP2   = 18;
  localparam int UCR_LOOP    = 19;
  localparam int UCR_TX_EN   = 20;
  localparam int UCR_RX_EN   = 21;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level count; a pop while full lets a simultaneous
// push through, a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 UART: programmable baud divisor, optional parity, 1/2 stop bits,
// TX/RX FIFOs, sticky W1C error flags and internal loopback.
module apb_uart_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int RESET_BAUD = 9600
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        tx
);
  localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / (RESET_BAUD * 16) - 1);

  logic [15:0] div, div_active, baud_cnt;
  logic        par_en, par_odd, stop2, loop_en, tx_en, rx_en;
  logic        tick;
  logic        access, wr_commit, tx_push, rx_pop, req_write, req_pop;
  logic [1:0]  req_addr;
  logic [21:0] req_wdata;
  logic [2:0]  w1c;
  logic [7:0]  last_tx;
  logic [31:0] usr, ucr, rd_data;
  logic        overrun, parity_err, frame_err, ovr_set, par_set, frm_set;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
  logic [7:0]  tx_head, rx_head;
  logic [LW-1:0] tx_level, rx_level;
  logic        unused_apb;

  assign unused_apb = ^{PADDR[1:0], PWDATA[31:22]};

  // Baud tick: a new divisor is only picked up when the counter reloads.
  assign tick = (baud_cnt == div_active);
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      baud_cnt   <= '0;
      div_active <= DIV_RST;
    end else if (tick) begin
      baud_cnt   <= '0;
      div_active <= div;
    end else begin
      baud_cnt   <= baud_cnt + 1'b1;
    end
  end

  assign access    = PSEL && PENABLE && !PREADY;
  assign wr_commit = PREADY && req_write;
  assign tx_push   = wr_commit && (req_addr == REG_UTX);
  assign rx_pop    = PREADY && req_pop;
  assign w1c       = (wr_commit && (req_addr == REG_USR)) ? req_wdata[6:4] : 3'b000;

  always_comb begin
    usr = '0;
    usr[USR_RX_NOT_EMPTY] = !rx_empty;
    usr[USR_TX_NOT_FULL]  = !tx_full;
    usr[USR_TX_EMPTY]     = tx_empty;
    usr[USR_RX_FULL]      = rx_full;
    usr[USR_OVERRUN]      = overrun;
    usr[USR_PARITY_ERR]   = parity_err;
    usr[USR_FRAME_ERR]    = frame_err;
    usr[USR_RX_LEVEL_LSB +: 8] = 8'(rx_level);
    usr[USR_TX_LEVEL_LSB +: 8] = 8'(tx_level);
    ucr = '0;
    ucr[15:0]        = div;
    ucr[UCR_PAR_EN]  = par_en;
    ucr[UCR_PAR_ODD] = par_odd;
    ucr[UCR_STOP2]   = stop2;
    ucr[UCR_LOOP]    = loop_en;
    ucr[UCR_TX_EN]   = tx_en;
    ucr[UCR_RX_EN]   = rx_en;
    case (PADDR[3:2])
      REG_USR: rd_data = usr;
      REG_UCR: rd_data = ucr;
      REG_UTX: rd_data = {24'b0, last_tx};
      default: rd_data = rx_empty ? 32'b0 : {24'b0, rx_head};
    endcase
  end

  // One wait state: capture in the first access cycle, complete in the next.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      req_pop   <= 1'b0;
    end else begin
      PREADY <= access;
      PRDATA <= access ? rd_data : 32'b0;
      if (access) begin
        req_addr  <= PADDR[3:2];
        req_write <= PWRITE;
        req_wdata <= PWDATA[21:0];
        req_pop   <= !PWRITE && (PADDR[3:2] == REG_URX) && !rx_empty;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      div     <= DIV_RST;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      stop2   <= 1'b0;
      loop_en <= 1'b0;
      tx_en   <= 1'b1;
      rx_en   <= 1'b1;
      last_tx <= '0;
    end else begin
      if (wr_commit && (req_addr == REG_UCR)) begin
        div     <= req_wdata[15:0];
        par_en  <= req_wdata[UCR_PAR_EN];
        par_odd <= req_wdata[UCR_PAR_ODD];
        stop2   <= req_wdata[UCR_STOP2];
        loop_en <= req_wdata[UCR_LOOP];
        tx_en   <= req_wdata[UCR_TX_EN];
        rx_en   <= req_wdata[UCR_RX_EN];
      end
      if (tx_push) last_tx <= req_wdata[7:0];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun    <= (overrun    && !w1c[0]) || ovr_set;
      parity_err <= (parity_err && !w1c[1]) || par_set;
      frame_err  <= (frame_err  && !w1c[2]) || frm_set;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .PCLK(PCLK), .PRESET(PRESET), .push(tx_push), .push_data(req_wdata[7:0]),
    .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_state_e tx_state;
  logic [3:0]  tx_tcnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_data;
  logic        tx_par_en, tx_par_odd, tx_stop2, tx_bit_end;

  assign tx_pop     = (tx_state == IDLE) && tx_en && !tx_empty;
  assign tx_bit_end = tick && (tx_tcnt == 4'd15);

  // Each bit spans 16 ticks; tx_tcnt wraps on its own at every bit boundary.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state   <= IDLE;
      tx         <= 1'b1;
      tx_tcnt    <= '0;
      tx_bit     <= '0;
      tx_data    <= '0;
      tx_par_en  <= 1'b0;
      tx_par_odd <= 1'b0;
      tx_stop2   <= 1'b0;
    end else begin
      if (tick && (tx_state != IDLE)) tx_tcnt <= tx_tcnt + 1'b1;
      case (tx_state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_pop) begin
            tx_state   <= START;
            tx         <= 1'b0;
            tx_data    <= tx_head;
            tx_par_en  <= par_en;
            tx_par_odd <= par_odd;
            tx_stop2   <= stop2;
            tx_tcnt    <= '0;
            tx_bit     <= '0;
          end
        end
        START: if (tx_bit_end) begin
          tx_state <= DATA;
          tx       <= tx_data[0];
        end
        DATA: if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            tx_bit <= '0;
            if (tx_par_en) begin
              tx_state <= PARITY;
              tx       <= (^tx_data) ^ tx_par_odd;
            end else begin
              tx_state <= STOP;
              tx       <= 1'b1;
            end
          end else begin
            tx_bit <= tx_bit + 1'b1;
            tx     <= tx_data[tx_bit + 3'd1];
          end
        end
        PARITY: if (tx_bit_end) begin
          tx_state <= STOP;
          tx       <= 1'b1;
        end
        STOP: if (tx_bit_end) begin
          if (tx_stop2 && (tx_bit == 3'd0)) begin
            tx_bit <= 3'd1;
          end else begin
            tx_bit   <= '0;
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_state_e rx_state;
  logic        rx_s1, rx_s2, rx_line, rx_sample, rx_loop, rx_par_en, rx_par_odd;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // The frame keeps the loop selection it started with.
  assign rx_line   = ((rx_state == IDLE) ? loop_en : rx_loop) ? tx : rx_s2;
  assign rx_sample = rx_en && tick && (rx_tcnt == 4'd15);
  assign par_set   = (rx_state == PARITY) && rx_sample && (((^rx_shift) ^ rx_line) != rx_par_odd);
  assign frm_set   = (rx_state == STOP) && rx_sample && !rx_line;
  assign ovr_set   = rx_push && rx_full && !rx_pop;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_state   <= IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_loop    <= 1'b0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_push    <= 1'b0;
    end else begin
      rx_push <= (rx_state == STOP) && rx_sample && rx_line;
      if (!rx_en) begin
        rx_state <= IDLE;
      end else begin
        if (tick && (rx_state != IDLE)) rx_tcnt <= rx_tcnt + 1'b1;
        case (rx_state)
          IDLE: if (!rx_line) begin
            rx_state   <= START;
            rx_tcnt    <= '0;
            rx_loop    <= loop_en;
            rx_par_en  <= par_en;
            rx_par_odd <= par_odd;
          end
          START: if (tick && (rx_tcnt == 4'd7)) begin
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? IDLE : DATA;
          end
          DATA: if (rx_sample) begin
            rx_shift <= {rx_line, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= rx_par_en ? PARITY : STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end
          PARITY: if (rx_sample) rx_state <= STOP;
          STOP:   if (rx_sample) rx_state <= IDLE;
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .PCLK(PCLK), .PRESET(PRESET), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed bench for apb_uart_ctrl: register reset values, loopback, TX
// parity/stop framing, RX parity/overrun/framing errors and mid-frame reset.
module tb_apb_uart_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx;
  logic        tx;

  int errors = 0;
  int checks = 0;

  apb_uart_ctrl #(.FIFO_DEPTH(8), .CLK_HZ(100_000_000), .RESET_BAUD(9600)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .rx(rx), .tx(tx)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One APB transfer: setup, access, then hold until the PREADY cycle is done.
  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    int waited;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waited = 0;
    do begin
      @(negedge PCLK);
      waited++;
    end while (!PREADY && waited < 8);
    checkOutput("pready_latency", 32'(waited), 32'd1);
    rdata = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    applyStimulus(1'b1, addr, wdata, dummy);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    logic [31:0] rdata;
    applyStimulus(1'b0, addr, 32'h0, rdata);
    checkOutput(tag, rdata, expected);
  endtask

  task automatic send_bit(input logic value);
    rx = value;
    repeat (16) @(negedge PCLK);
  endtask

  task automatic drive_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                             input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx = 1'b1;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic wait_tx_low(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge PCLK);
      n++;
    end
    if (tx !== 1'b0) checkOutput(tag, {31'b0, tx}, 32'd0);
  endtask

  initial begin
    logic exp_bits [12];
    int t;
    int lows;

    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    rx = 1'b1;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    checkOutput("reset_pready", {31'b0, PREADY}, 32'd0);
    checkOutput("reset_prdata", PRDATA, 32'h0);
    PRESET = 1'b0;
    read_check("reset_usr", 4'h0, 32'h0000_0006);
    read_check("reset_ucr", 4'h4, 32'h0030_028A);

    // Loopback at div=0; wait out the reset divisor before sending.
    apb_write(4'h4, 32'h0038_0000);
    read_check("ucr_loop", 4'h4, 32'h0038_0000);
    repeat (700) @(negedge PCLK);
    apb_write(4'h8, 32'h0000_0055);
    apb_write(4'h8, 32'h0000_00A3);
    read_check("utx_last", 4'h8, 32'h0000_00A3);
    repeat (450) @(negedge PCLK);
    read_check("loop_usr_lvl2", 4'h0, 32'h0002_0007);
    read_check("loop_urx_0", 4'hC, 32'h0000_0055);
    read_check("loop_usr_lvl1", 4'h0, 32'h0001_0007);
    read_check("loop_urx_1", 4'hC, 32'h0000_00A3);
    read_check("loop_usr_lvl0", 4'h0, 32'h0000_0006);
    read_check("loop_urx_empty", 4'hC, 32'h0000_0000);

    // TX odd parity with two stop bits, two queued frames of 0x07.
    apb_write(4'h4, 32'h0027_0000);
    apb_write(4'h8, 32'h0000_0007);
    apb_write(4'h8, 32'h0000_0007);
    read_check("tx_queued_usr", 4'h0, 32'h0200_0002);
    apb_write(4'h4, 32'h0037_0000);
    wait_tx_low("tx_start_timeout");
    exp_bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t = 0;
    for (int k = 0; k < 12; k++) begin
      repeat ((k == 0) ? 8 : 16) @(negedge PCLK);
      t += (k == 0) ? 8 : 16;
      checkOutput($sformatf("tx_bit_%0d", k), {31'b0, tx}, {31'b0, exp_bits[k]});
    end
    while (tx === 1'b1 && t < 400) begin
      @(negedge PCLK);
      t++;
    end
    checkOutput("tx_stop2_gap", 32'(t), 32'd193);
    repeat (220) @(negedge PCLK);
    read_check("tx_done_usr", 4'h0, 32'h0000_0006);

    // RX even parity with a wrong parity bit: byte kept, parity_err raised.
    apb_write(4'h4, 32'h0031_0000);
    drive_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    read_check("par_err_usr", 4'h0, 32'h0001_0027);
    read_check("par_err_urx", 4'hC, 32'h0000_003C);
    apb_write(4'h0, 32'h0000_0020);
    read_check("par_err_cleared", 4'h0, 32'h0000_0006);

    // Overrun: one frame more than the FIFO holds, then a framing error.
    apb_write(4'h4, 32'h0030_0000);
    for (int i = 0; i < 9; i++) drive_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    read_check("overrun_usr", 4'h0, 32'h0008_001F);
    drive_frame(8'h99, 1'b0, 1'b0, 1'b0);
    read_check("frame_err_usr", 4'h0, 32'h0008_005F);
    for (int i = 0; i < 8; i++) read_check($sformatf("fifo_byte_%0d", i), 4'hC, 32'h10 + 32'(i));
    read_check("flags_sticky", 4'h0, 32'h0000_0056);
    apb_write(4'h0, 32'h0000_0070);
    read_check("flags_cleared", 4'h0, 32'h0000_0006);

    // Reset mid data bit of a 0x00 frame with another byte still queued.
    apb_write(4'h8, 32'h0000_0000);
    apb_write(4'h8, 32'h0000_0000);
    wait_tx_low("rst_start_timeout");
    repeat (40) @(negedge PCLK);
    checkOutput("tx_mid_frame", {31'b0, tx}, 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    checkOutput("tx_after_reset", {31'b0, tx}, 32'd1);
    PRESET = 1'b0;
    read_check("usr_after_reset", 4'h0, 32'h0000_0006);
    read_check("ucr_after_reset", 4'h4, 32'h0030_028A);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("tx_quiet_after_reset", 32'(lows), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
